// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0
// ============================================================================
package dmem_pkg;

    localparam int   DEFAULT_LEN_W = 4;
    localparam int   WORD_BYTES    = 4;
    localparam logic REQ_CPU       = 1'b0;
    localparam logic REQ_AUX       = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Combinational two-way round-robin pick; rr_ptr breaks ties.
//  Revision    : 1.0
// ============================================================================
module rr_arbiter_2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       winner,
    output logic       any_win
);

    always_comb begin
        any_win = |req;
        winner  = REQ_CPU;
        if (req == 2'b11) begin
            winner = rr_ptr;
        end else if (req[1]) begin
            winner = REQ_AUX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Burst-granting round-robin arbiter sharing one data memory
//                between the CPU port (r0) and an auxiliary engine (r1).
//  Revision    : 1.0
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              r1_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int          C_WB_SH     = $clog2(WORD_BYTES);
    localparam [ADDR_W-1:0] C_ALIGN_MSK = ~ADDR_W'(WORD_BYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_ptr;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_cnt;
    logic [LEN_W-1:0]    r_beat;
    logic [1:0]          r_done;
    logic [1:0]          r_rvalid;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;

    logic                w_winner;
    logic                w_any_win;
    logic                w_owner_req;
    logic                w_arb_en;
    logic                w_win;
    logic                w_issue;
    logic                w_last;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_beat_addr;

    rr_arbiter_2 u_rr (
        .req     ({r1_req, r0_req}),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any_win (w_any_win)
    );

    assign w_owner_req = (r_owner == REQ_AUX) ? r1_req : r0_req;
    // The done cycle is held off from arbitration, leaving a bubble between bursts.
    assign w_arb_en    = (r_state == IDLE) && (r_done == 2'b00) && !rst;
    assign w_win       = w_arb_en && w_any_win;
    assign w_issue     = (r_state == BURST) && w_owner_req && !rst;
    assign w_last      = w_issue && (r_cnt == '0);
    assign w_abort     = (r_state == BURST) && !w_owner_req;
    assign w_beat_addr = r_base + (ADDR_W'(r_beat) << C_WB_SH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                busy = !rst;
                if (w_last || w_abort) begin
                    w_state_nxt = IDLE;
                end
                if (w_issue) begin
                    r0_gnt    = (r_owner == REQ_CPU);
                    r1_gnt    = (r_owner == REQ_AUX);
                    mem_read  = !r_we;
                    mem_write = r_we;
                    mem_addr  = w_beat_addr;
                    mem_wdata = (r_owner == REQ_AUX) ? r1_wdata : r0_wdata;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= REQ_CPU;
            r_owner  <= REQ_CPU;
            r_we     <= 1'b0;
            r_base   <= '0;
            r_cnt    <= '0;
            r_beat   <= '0;
            r_done   <= 2'b00;
            r_rvalid <= 2'b00;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done[0]   <= w_last && (r_owner == REQ_CPU);
            r_done[1]   <= w_last && (r_owner == REQ_AUX);
            r_rvalid[0] <= w_issue && !r_we && (r_owner == REQ_CPU);
            r_rvalid[1] <= w_issue && !r_we && (r_owner == REQ_AUX);
            if (w_issue && !r_we) begin
                if (r_owner == REQ_AUX) begin
                    r_rdata1 <= mem_rdata;
                end else begin
                    r_rdata0 <= mem_rdata;
                end
            end
            if (w_win) begin
                r_owner <= w_winner;
                r_we    <= (w_winner == REQ_AUX) ? r1_we : r0_we;
                r_base  <= ((w_winner == REQ_AUX) ? r1_addr : r0_addr) & C_ALIGN_MSK;
                r_cnt   <= (w_winner == REQ_AUX) ? r1_len : r0_len;
                r_beat  <= '0;
            end
            if (w_issue) begin
                r_cnt  <= r_cnt - 1'b1;
                r_beat <= r_beat + 1'b1;
            end
            // Completed or abandoned, the burst hands priority to the other side.
            if (w_last || w_abort) begin
                r_rr_ptr <= ~r_owner;
            end
        end
    end

    assign r0_done   = r_done[0];
    assign r1_done   = r_done[1];
    assign r0_rvalid = r_rvalid[0];
    assign r1_rvalid = r_rvalid[1];
    assign r0_rdata  = r_rdata0;
    assign r1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed bench for dmem_arbiter with a word-indexed memory model.
//  Revision    : 1.0
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clear;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [3:0]  r0_len, r1_len;
    logic        r0_gnt, r0_rvalid, r0_done, r1_gnt, r1_rvalid, r1_done;
    logic [31:0] r0_rdata, r1_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:1023];
    logic [31:0] t1_exp [4];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_len(r0_len),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rdata(r0_rdata),
        .r0_rvalid(r0_rvalid), .r0_done(r0_done),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_len(r1_len),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rdata(r1_rdata),
        .r1_rvalid(r1_rvalid), .r1_done(r1_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input logic [9:0] idx);
        case (idx)
            10'd0:   return 32'h3DFBF0BE;
            10'd1:   return 32'h3E8BF7CF;
            10'd2:   return 32'h3E300000;
            10'd3:   return 32'h3EB4978D;
            default: return 32'hD0000000 | {22'd0, idx};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i[9:0]);
        end else if (mem_write) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic g0, input logic g1,
                             input logic rd, input logic wr, input logic [31:0] addr);
        chk({tag, ".gnt0"}, {31'd0, r0_gnt}, {31'd0, g0});
        chk({tag, ".gnt1"}, {31'd0, r1_gnt}, {31'd0, g1});
        chk({tag, ".mrd"},  {31'd0, mem_read}, {31'd0, rd});
        chk({tag, ".mwr"},  {31'd0, mem_write}, {31'd0, wr});
        chk({tag, ".addr"}, mem_addr, addr);
    endtask

    task automatic chk_quiet(input string tag);
        chk_issue(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk({tag, ".wdata"}, mem_wdata, 32'h0);
        chk({tag, ".busy"},  {31'd0, busy}, 32'h0);
        chk({tag, ".done"},  {30'd0, r1_done, r0_done}, 32'h0);
        chk({tag, ".rv"},    {30'd0, r1_rvalid, r0_rvalid}, 32'h0);
        chk({tag, ".rd0"},   r0_rdata, 32'h0);
        chk({tag, ".rd1"},   r1_rdata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        t1_exp = '{32'h3DFBF0BE, 32'h3E8BF7CF, 32'h3E300000, 32'h3EB4978D};
        rst = 1'b1; mem_clear = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_len = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_len = 0; r1_wdata = 0;
        tick();
        chk_quiet("reset");
        tick();
        rst = 1'b0; mem_clear = 1'b0;

        // Test 1: r0 read burst, addr 0, len 3
        r0_req = 1; r0_we = 0; r0_addr = 32'h0; r0_len = 4'd3;
        #1;
        chk_issue("t1.c0", 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk_issue($sformatf("t1.b%0d", i), 1, 0, 1, 0, 32'(i * 4));
            chk("t1.rv", {31'd0, r0_rvalid}, {31'd0, (i > 0)});
            chk("t1.done_early", {31'd0, r0_done}, 32'h0);
            if (i > 0) chk("t1.rdata", r0_rdata, t1_exp[i-1]);
        end
        tick(); #1;
        chk_issue("t1.c5", 0, 0, 0, 0, 32'h0);
        chk("t1.done", {31'd0, r0_done}, 32'h1);
        chk("t1.rv_last", {31'd0, r0_rvalid}, 32'h1);
        chk("t1.rd_last", r0_rdata, t1_exp[3]);
        r0_req = 0;
        tick(); #1;
        chk("t1.done_clr", {31'd0, r0_done}, 32'h0);
        chk("t1.rv_clr", {31'd0, r0_rvalid}, 32'h0);
        chk("t1.rd_hold", r0_rdata, t1_exp[3]);

        // Test 2: r1 write 0x320 len 1, then read back
        r1_req = 1; r1_we = 1; r1_addr = 32'h320; r1_len = 4'd1; r1_wdata = 32'hAAAA0001;
        tick(); #1;
        chk_issue("t2.w0", 0, 1, 0, 1, 32'h320);
        chk("t2.wd0", mem_wdata, 32'hAAAA0001);
        tick();
        r1_wdata = 32'hAAAA0002;
        #1;
        chk_issue("t2.w1", 0, 1, 0, 1, 32'h324);
        chk("t2.wd1", mem_wdata, 32'hAAAA0002);
        tick(); #1;
        chk("t2.wdone", {31'd0, r1_done}, 32'h1);
        chk("t2.wrv", {31'd0, r1_rvalid}, 32'h0);
        chk("t2.mem200", mem[200], 32'hAAAA0001);
        chk("t2.mem201", mem[201], 32'hAAAA0002);
        r1_req = 0;
        tick();
        r1_req = 1; r1_we = 0;
        tick(); #1;
        chk_issue("t2.r0", 0, 1, 1, 0, 32'h320);
        tick(); #1;
        chk_issue("t2.r1", 0, 1, 1, 0, 32'h324);
        chk("t2.rd0", r1_rdata, 32'hAAAA0001);
        tick(); #1;
        chk("t2.rdone", {31'd0, r1_done}, 32'h1);
        chk("t2.rd1", r1_rdata, 32'hAAAA0002);
        r1_req = 0;

        // Test 3: contention at reset exit, rr order 0,1,0
        tick();
        rst = 1;
        r0_req = 1; r0_we = 0; r0_addr = 32'h10; r0_len = 4'd1;
        r1_req = 1; r1_we = 0; r1_addr = 32'h40; r1_len = 4'd0;
        #1;
        chk_issue("t3.rst", 0, 0, 0, 0, 32'h0);
        tick();
        rst = 0;
        #1;
        chk_issue("t3.arb", 0, 0, 0, 0, 32'h0);
        tick(); #1;
        chk_issue("t3.a0", 1, 0, 1, 0, 32'h10);
        tick(); #1;
        chk_issue("t3.a1", 1, 0, 1, 0, 32'h14);
        tick(); #1;
        chk("t3.adone", {31'd0, r0_done}, 32'h1);
        chk("t3.ard", r0_rdata, 32'hD0000005);
        chk_issue("t3.bubble0", 0, 0, 0, 0, 32'h0);
        r0_req = 0;
        tick();
        r0_req = 1; r0_addr = 32'h20; r0_len = 4'd0;
        #1;
        chk_issue("t3.bubble1", 0, 0, 0, 0, 32'h0);
        chk("t3.busy_idle", {31'd0, busy}, 32'h0);
        tick(); #1;
        chk_issue("t3.b0", 0, 1, 1, 0, 32'h40);
        tick(); #1;
        chk("t3.bdone", {31'd0, r1_done}, 32'h1);
        chk("t3.brd", r1_rdata, 32'hD0000010);
        r1_req = 0;
        tick(); #1;
        chk_issue("t3.arb2", 0, 0, 0, 0, 32'h0);
        tick(); #1;
        chk_issue("t3.c0", 1, 0, 1, 0, 32'h20);
        tick(); #1;
        chk("t3.cdone", {31'd0, r0_done}, 32'h1);
        chk("t3.crd", r0_rdata, 32'hD0000008);
        r0_req = 0;

        // Test 4: r1 write len 7 aborted after two beats; r0 waiting wins next
        tick();
        r1_req = 1; r1_we = 1; r1_addr = 32'h400; r1_len = 4'd7; r1_wdata = 32'hBBBB0000;
        r0_req = 1; r0_we = 0; r0_addr = 32'h8; r0_len = 4'd0;
        tick(); #1;
        chk_issue("t4.w0", 0, 1, 0, 1, 32'h400);
        tick();
        r1_wdata = 32'hBBBB0001;
        #1;
        chk_issue("t4.w1", 0, 1, 0, 1, 32'h404);
        tick();
        r1_req = 0;
        #1;
        chk_issue("t4.abort", 0, 0, 0, 0, 32'h0);
        chk("t4.nodone_a", {31'd0, r1_done}, 32'h0);
        tick(); #1;
        chk("t4.busy", {31'd0, busy}, 32'h0);
        chk("t4.nodone_b", {31'd0, r1_done}, 32'h0);
        chk("t4.mem256", mem[256], 32'hBBBB0000);
        chk("t4.mem257", mem[257], 32'hBBBB0001);
        chk("t4.mem258", mem[258], 32'hD0000102);
        tick(); #1;
        chk_issue("t4.r0win", 1, 0, 1, 0, 32'h8);
        tick(); #1;
        chk("t4.r0done", {31'd0, r0_done}, 32'h1);
        chk("t4.r0rd", r0_rdata, 32'h3E300000);
        r0_req = 0;

        // Test 5: reset during third beat of a len 5 write
        tick();
        r0_req = 1; r0_we = 1; r0_addr = 32'h600; r0_len = 4'd5; r0_wdata = 32'hCCCC0000;
        tick(); #1;
        chk_issue("t5.w0", 1, 0, 0, 1, 32'h600);
        tick();
        r0_wdata = 32'hCCCC0001;
        tick();
        r0_wdata = 32'hCCCC0002;
        rst = 1;
        #1;
        chk_issue("t5.rstbeat", 0, 0, 0, 0, 32'h0);
        chk("t5.rstbusy", {31'd0, busy}, 32'h0);
        tick();
        rst = 0; r0_req = 0;
        #1;
        chk_quiet("t5.after");
        chk("t5.mem384", mem[384], 32'hCCCC0000);
        chk("t5.mem385", mem[385], 32'hCCCC0001);
        chk("t5.mem386", mem[386], 32'hD0000182);
        tick();
        r1_req = 1; r1_we = 0; r1_addr = 32'h0; r1_len = 4'd0;
        tick(); #1;
        chk_issue("t5.fresh", 0, 1, 1, 0, 32'h0);
        tick(); #1;
        chk("t5.fdone", {31'd0, r1_done}, 32'h1);
        chk("t5.frd", r1_rdata, 32'h3DFBF0BE);
        r1_req = 0;

        // Test 6: unaligned base near the top of the address space wraps
        tick();
        r0_req = 1; r0_we = 0; r0_addr = 32'hFFFFFFFE; r0_len = 4'd1;
        tick(); #1;
        chk_issue("t6.b0", 1, 0, 1, 0, 32'hFFFFFFFC);
        tick(); #1;
        chk_issue("t6.b1", 1, 0, 1, 0, 32'h00000000);
        chk("t6.rd0", r0_rdata, 32'hD00003FF);
        tick(); #1;
        chk("t6.done", {31'd0, r0_done}, 32'h1);
        chk("t6.rd1", r0_rdata, 32'h3DFBF0BE);
        r0_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
